// File: rtl/ysyx_25020037_scoreboard.sv
// Issue-hazard scheduler between IDU and EXU.
// Tracks in-flight GPR writers and outstanding loads per register. Issue is held
// on load-use hazards, per-register writer-count saturation, and for serializing
// instructions until the pipeline has drained. ALU hazards rely on EXU bypass.
module ysyx_25020037_scoreboard #(
  parameter int NR_REG = 16,
  parameter int CNT_W  = 2,
  parameter int INF_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [$clog2(NR_REG)-1:0] issue_rs1,
  input  logic [$clog2(NR_REG)-1:0] issue_rs2,
  input  logic [$clog2(NR_REG)-1:0] issue_rd,
  input  logic                      issue_we,
  input  logic                      issue_is_load,
  input  logic                      issue_serial,
  input  logic                      redirect,
  output logic                      issue_ready,
  output logic                      issue_fire,
  input  logic                      load_done,
  input  logic [$clog2(NR_REG)-1:0] load_rd,
  input  logic                      wb_valid,
  input  logic [$clog2(NR_REG)-1:0] wb_rd,
  output logic [INF_W-1:0]          inflight,
  output logic                      drain_busy,
  output logic [31:0]               stall_cycles,
  output logic                      err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   wr_cnt_q [NR_REG];
  logic [CNT_W-1:0]   wr_cnt_d [NR_REG];
  logic [CNT_W-1:0]   ld_cnt_q [NR_REG];
  logic [CNT_W-1:0]   ld_cnt_d [NR_REG];
  logic [INF_W-1:0]   inflight_q, inflight_d;
  logic [31:0]        stall_q;
  logic               err_q, err_d;

  logic               load_use, waw_sat, ser_block, hazard;
  logic               alloc, retire, ld_ret;
  logic [NR_REG-1:0]  wr_inc, wr_dec, ld_inc, ld_dec;

  // Hazard detection from the registered counters only (no same-cycle bypass)
  always_comb begin
    load_use  = 1'b0;
    if (issue_rs1 != '0 && ld_cnt_q[issue_rs1] != '0) load_use = 1'b1;
    if (issue_rs2 != '0 && ld_cnt_q[issue_rs2] != '0) load_use = 1'b1;
    waw_sat   = issue_we && (issue_rd != '0) && (wr_cnt_q[issue_rd] == CNT_MAX);
    ser_block = issue_serial && (inflight_q != '0);
    hazard    = load_use || waw_sat || ser_block;
  end

  assign issue_ready = !rst && !hazard;
  assign issue_fire  = issue_valid && issue_ready && !redirect;

  // x0 never allocates, retires or returns a load
  assign alloc  = issue_fire && issue_we && (issue_rd != '0);
  assign retire = wb_valid && (wb_rd != '0);
  assign ld_ret = load_done && (load_rd != '0);

  // One-hot per-register increment/decrement requests
  always_comb begin
    wr_inc = alloc  ? (NR_REG'(1) << issue_rd) : '0;
    ld_inc = (alloc && issue_is_load) ? (NR_REG'(1) << issue_rd) : '0;
    wr_dec = retire ? (NR_REG'(1) << wb_rd)   : '0;
    ld_dec = ld_ret ? (NR_REG'(1) << load_rd) : '0;
  end

  // Next-state counters: inc+dec cancels, decrement of zero holds and flags
  always_comb begin
    err_d      = err_q;
    inflight_d = inflight_q;
    for (int r = 0; r < NR_REG; r++) begin
      wr_cnt_d[r] = wr_cnt_q[r];
      ld_cnt_d[r] = ld_cnt_q[r];
      if (wr_inc[r] && !wr_dec[r]) begin
        wr_cnt_d[r] = wr_cnt_q[r] + CNT_W'(1);
      end else if (!wr_inc[r] && wr_dec[r]) begin
        if (wr_cnt_q[r] == '0) err_d = 1'b1;
        else                   wr_cnt_d[r] = wr_cnt_q[r] - CNT_W'(1);
      end
      if (ld_inc[r] && !ld_dec[r]) begin
        ld_cnt_d[r] = ld_cnt_q[r] + CNT_W'(1);
      end else if (!ld_inc[r] && ld_dec[r]) begin
        if (ld_cnt_q[r] == '0) err_d = 1'b1;
        else                   ld_cnt_d[r] = ld_cnt_q[r] - CNT_W'(1);
      end
    end
    if (alloc && !retire) begin
      if (inflight_q != '1) inflight_d = inflight_q + INF_W'(1);
    end else if (!alloc && retire) begin
      if (inflight_q == '0) err_d = 1'b1;
      else                  inflight_d = inflight_q - INF_W'(1);
    end
  end

  // Counter, error and perf state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR_REG; r++) begin
        wr_cnt_q[r] <= '0;
        ld_cnt_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
    end else begin
      for (int r = 0; r < NR_REG; r++) begin
        wr_cnt_q[r] <= wr_cnt_d[r];
        ld_cnt_q[r] <= ld_cnt_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (issue_valid && !issue_ready && !redirect) stall_q <= stall_q + 32'd1;
    end
  end

  // RUN/DRAIN FSM: a serializing instruction waits in DRAIN until it issues or is squashed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (issue_valid && issue_serial && (inflight_q != '0) && !redirect)
                   state_q <= DRAIN;
        DRAIN:   if (issue_fire || redirect)
                   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign inflight      = inflight_q;
  assign drain_busy    = (state_q == DRAIN);
  assign stall_cycles  = stall_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ysyx_25020037_scoreboard.sv
// Bench for the issue scoreboard: directed vector table followed by random traffic,
// all checked against a behavioural per-register count model.
module tb_ysyx_25020037_scoreboard;

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_we, issue_is_load, issue_serial, redirect;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd, load_rd, wb_rd;
  logic        load_done, wb_valid;
  logic        issue_ready, issue_fire, drain_busy, err_underflow;
  logic [5:0]  inflight;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  ysyx_25020037_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_is_load(issue_is_load), .issue_serial(issue_serial), .redirect(redirect),
    .issue_ready(issue_ready), .issue_fire(issue_fire), .load_done(load_done),
    .load_rd(load_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .inflight(inflight),
    .drain_busy(drain_busy), .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );

  typedef struct {
    logic rst, v;
    logic [3:0] rs1, rs2, rd;
    logic we, ld, ser, redir, ldd;
    logic [3:0] ldrd;
    logic wb;
    logic [3:0] wbrd;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  rdy, fire;
    int    inf;
    logic  drain, err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding writer / load counts per register
  int          m_wr [16];
  int          m_ld [16];
  int          m_inf = 0;
  bit          m_drain = 0;
  bit          m_err = 0;
  int unsigned m_stall = 0;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit v, int rs1, int rs2, int rd, bit we, bit ld, bit ser,
                              bit redir, bit ldd, int ldrd, bit wb, int wbrd,
                              bit rdy, bit fire, int inf, bit drain, bit err);
    vec_t t;
    t.s.rst = r; t.s.v = v; t.s.rs1 = 4'(rs1); t.s.rs2 = 4'(rs2); t.s.rd = 4'(rd);
    t.s.we = we; t.s.ld = ld; t.s.ser = ser; t.s.redir = redir; t.s.ldd = ldd;
    t.s.ldrd = 4'(ldrd); t.s.wb = wb; t.s.wbrd = 4'(wbrd);
    t.rdy = rdy; t.fire = fire; t.inf = inf; t.drain = drain; t.err = err;
    return t;
  endfunction

  function automatic bit model_ready(stim_t s);
    bit hz;
    if (s.rst) return 1'b0;
    hz = (s.rs1 != 0 && m_ld[s.rs1] > 0) || (s.rs2 != 0 && m_ld[s.rs2] > 0) ||
         (s.we && s.rd != 0 && m_wr[s.rd] == 3) || (s.ser && m_inf != 0);
    return !hz;
  endfunction

  task automatic model_step(input stim_t s, input bit rdy, input bit fire);
    int n, d;
    if (s.rst) begin
      for (int r = 0; r < 16; r++) begin m_wr[r] = 0; m_ld[r] = 0; end
      m_inf = 0; m_drain = 0; m_err = 0; m_stall = 0;
      return;
    end
    if (!m_drain) m_drain = s.v && s.ser && (m_inf != 0) && !s.redir;
    else if (fire || s.redir) m_drain = 0;
    if (s.v && !rdy && !s.redir) m_stall++;
    for (int r = 1; r < 16; r++) begin
      d = int'(fire && s.we && s.rd == r) - int'(s.wb && s.wbrd == r);
      n = m_wr[r] + d;
      if (n < 0) begin m_err = 1; n = 0; end
      m_wr[r] = n;
      d = int'(fire && s.we && s.ld && s.rd == r) - int'(s.ldd && s.ldrd == r);
      n = m_ld[r] + d;
      if (n < 0) begin m_err = 1; n = 0; end
      m_ld[r] = n;
    end
    n = m_inf + int'(fire && s.we && s.rd != 0) - int'(s.wb && s.wbrd != 0);
    if (n < 0) begin m_err = 1; n = 0; end
    if (n > 63) n = 63;
    m_inf = n;
  endtask

  task automatic apply(input vec_t e, input bit has_exp);
    bit rdy, fire;
    rst = e.s.rst; issue_valid = e.s.v; issue_rs1 = e.s.rs1; issue_rs2 = e.s.rs2;
    issue_rd = e.s.rd; issue_we = e.s.we; issue_is_load = e.s.ld; issue_serial = e.s.ser;
    redirect = e.s.redir; load_done = e.s.ldd; load_rd = e.s.ldrd;
    wb_valid = e.s.wb; wb_rd = e.s.wbrd;
    #1;
    rdy  = model_ready(e.s);
    fire = e.s.v && rdy && !e.s.redir;
    chk("issue_ready", 32'(issue_ready), 32'(rdy));
    chk("issue_fire", 32'(issue_fire), 32'(fire));
    if (has_exp) begin
      chk("tbl_ready", 32'(issue_ready), 32'(e.rdy));
      chk("tbl_fire", 32'(issue_fire), 32'(e.fire));
    end
    @(posedge clk);
    model_step(e.s, rdy, fire);
    #1;
    chk("inflight", 32'(inflight), 32'(m_inf));
    chk("drain_busy", 32'(drain_busy), 32'(m_drain));
    chk("stall_cycles", stall_cycles, m_stall);
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
    if (has_exp) begin
      chk("tbl_inflight", 32'(inflight), 32'(e.inf));
      chk("tbl_drain", 32'(drain_busy), 32'(e.drain));
      chk("tbl_err", 32'(err_underflow), 32'(e.err));
    end
  endtask

  function automatic logic [3:0] pick(bit use_ld);
    int q[$];
    if ($urandom_range(0, 19) == 0) return 4'($urandom_range(0, 15));
    for (int r = 1; r < 16; r++)
      if ((use_ld ? m_ld[r] : m_wr[r]) > 0) q.push_back(r);
    if (q.size() == 0) return 4'($urandom_range(0, 15));
    return 4'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  initial begin
    vec_t rv;
    for (int r = 0; r < 16; r++) begin m_wr[r] = 0; m_ld[r] = 0; end
    //           rst v rs1 rs2 rd we ld ser rdr ldd ldrd wb wbrd | rdy fire inf drn err
    tbl.push_back(mk(1,1, 0,0, 1, 1,0,0,0, 0,0, 0,0,  0,0,0,0,0));
    tbl.push_back(mk(1,0, 0,0, 0, 0,0,0,0, 0,0, 0,0,  0,0,0,0,0));
    tbl.push_back(mk(1,0, 0,0, 0, 0,0,0,0, 0,0, 0,0,  0,0,0,0,0));
    // ALU back-to-back, no stall
    tbl.push_back(mk(0,1, 0,0, 3, 1,0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 3,0, 2, 1,0,0,0, 0,0, 0,0,  1,1,2,0,0));
    // load-use
    tbl.push_back(mk(0,1, 0,0, 5, 1,1,0,0, 0,0, 0,0,  1,1,3,0,0));
    tbl.push_back(mk(0,1, 5,0, 6, 1,0,0,0, 0,0, 0,0,  0,0,3,0,0));
    tbl.push_back(mk(0,1, 5,0, 6, 1,0,0,0, 1,5, 0,0,  0,0,3,0,0));
    tbl.push_back(mk(0,1, 5,0, 6, 1,0,0,0, 0,0, 0,0,  1,1,4,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,3,  1,0,3,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,2,  1,0,2,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,5,  1,0,1,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,6,  1,0,0,0,0));
    // writer saturation on x7
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 0,0,  1,1,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 0,0,  1,1,3,0,0));
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 0,0,  0,0,3,0,0));
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 1,7,  0,0,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 0,0,  1,1,3,0,0));
    tbl.push_back(mk(0,1, 0,0, 7, 1,0,0,0, 0,0, 0,0,  0,0,3,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,7,  1,0,2,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,7,  1,0,1,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,7,  1,0,0,0,0));
    // serializing instruction drains, then a squashed one in DRAIN
    tbl.push_back(mk(0,1, 0,0, 8, 1,0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 9, 1,0,0,0, 0,0, 0,0,  1,1,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 0, 0,0,1,0, 0,0, 0,0,  0,0,2,1,0));
    tbl.push_back(mk(0,1, 0,0, 0, 0,0,1,0, 0,0, 1,8,  0,0,1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0, 0,0,1,0, 0,0, 1,9,  0,0,0,1,0));
    tbl.push_back(mk(0,1, 0,0, 0, 0,0,1,0, 0,0, 0,0,  1,1,0,0,0));
    tbl.push_back(mk(0,1, 0,0,10, 1,0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 0, 0,0,1,0, 0,0, 0,0,  0,0,1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0, 0,0,1,1, 0,0, 0,0,  0,0,1,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,10, 1,0,0,0,0));
    // same-cycle inc+dec on x4 keeps count at 1 (two more fit, third stalls)
    tbl.push_back(mk(0,1, 0,0, 4, 1,0,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 4, 1,0,0,0, 0,0, 1,4,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 4, 1,0,0,0, 0,0, 0,0,  1,1,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 4, 1,0,0,0, 0,0, 0,0,  1,1,3,0,0));
    tbl.push_back(mk(0,1, 0,0, 4, 1,0,0,0, 0,0, 0,0,  0,0,3,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,4,  1,0,2,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,4,  1,0,1,0,0));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,4,  1,0,0,0,0));
    // underflow on x9: sticky flag, count holds at 0 (three writes fit)
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,9,  1,0,0,0,1));
    tbl.push_back(mk(0,1, 0,0, 9, 1,0,0,0, 0,0, 0,0,  1,1,1,0,1));
    tbl.push_back(mk(0,1, 0,0, 9, 1,0,0,0, 0,0, 0,0,  1,1,2,0,1));
    tbl.push_back(mk(0,1, 0,0, 9, 1,0,0,0, 0,0, 0,0,  1,1,3,0,1));
    tbl.push_back(mk(0,1, 0,0, 9, 1,0,0,0, 0,0, 0,0,  0,0,3,0,1));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,9,  1,0,2,0,1));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,9,  1,0,1,0,1));
    tbl.push_back(mk(0,0, 0,0, 0, 0,0,0,0, 0,0, 1,9,  1,0,0,0,1));
    // reset mid-traffic clears load tracking, error and inflight
    tbl.push_back(mk(0,1, 0,0,11, 1,1,0,0, 0,0, 0,0,  1,1,1,0,1));
    tbl.push_back(mk(1,1, 0,0,12, 1,0,0,0, 0,0, 0,0,  0,0,0,0,0));
    tbl.push_back(mk(1,1, 0,0,12, 1,0,0,0, 0,0, 0,0,  0,0,0,0,0));
    tbl.push_back(mk(1,1, 0,0,12, 1,0,0,0, 0,0, 0,0,  0,0,0,0,0));
    tbl.push_back(mk(0,1,11,0, 0, 0,0,0,0, 0,0, 0,0,  1,1,0,0,0));
    // load-use through rs2
    tbl.push_back(mk(0,1, 0,0,13, 1,1,0,0, 0,0, 0,0,  1,1,1,0,0));
    tbl.push_back(mk(0,1, 1,13,2, 1,0,0,0, 0,0, 0,0,  0,0,1,0,0));

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rv = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      rv.s.rst   = ($urandom_range(0, 199) == 0);
      rv.s.v     = ($urandom_range(0, 9) < 7);
      rv.s.rs1   = 4'($urandom_range(0, 15));
      rv.s.rs2   = 4'($urandom_range(0, 15));
      rv.s.rd    = 4'($urandom_range(0, 15));
      rv.s.we    = ($urandom_range(0, 9) < 7);
      rv.s.ld    = rv.s.we && ($urandom_range(0, 9) < 3) && (m_ld[rv.s.rd] < 3);
      rv.s.ser   = ($urandom_range(0, 19) == 0);
      rv.s.redir = ($urandom_range(0, 19) == 0);
      rv.s.ldd   = ($urandom_range(0, 9) < 3);
      rv.s.ldrd  = pick(1'b1);
      rv.s.wb    = ($urandom_range(0, 9) < 4);
      rv.s.wbrd  = pick(1'b0);
      apply(rv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
